// File: rtl/alu_pkg.sv
// Shared definitions for the sequential carry-lookahead adder/subtractor:
// FSM encoding, default geometry and group-index sizing.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_GROUP = 4;
    localparam int DEF_IDX_W = $clog2(DEF_WIDTH / DEF_GROUP);

    // A single-group configuration still needs a 1-bit index register
    function automatic int idx_width(input int n_groups);
        return (n_groups > 1) ? $clog2(n_groups) : 1;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice: every carry is a flattened
// sum-of-products of generate/propagate terms and cin, with no ripple chain.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;

    assign p    = a ^ b;
    assign g    = a & b;
    assign c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < GROUP; gi++) begin : g_carry
            logic carry;

            // c[gi+1] = g[gi] | p[gi]g[gi-1] | ... | p[gi..0]cin
            always_comb begin
                logic term;
                logic acc;
                term = cin;
                for (int m = 0; m <= gi; m++) begin
                    term = term & p[m];
                end
                acc = term;
                for (int j = 0; j <= gi; j++) begin
                    term = g[j];
                    for (int m = j + 1; m <= gi; m++) begin
                        term = term & p[m];
                    end
                    acc = acc | term;
                end
                carry = acc;
            end

            assign c[gi+1] = carry;
        end
    endgenerate

    assign sum   = p ^ c[GROUP-1:0];
    assign c_out = c[GROUP];
    assign c_msb = c[GROUP-1];

endmodule

// File: rtl/seq_carry_lookahead_addsub.sv
// Multi-cycle adder/subtractor: one lookahead group per cycle, with
// valid/ready handshakes on operands and result, plus carry/overflow/zero flags.
module seq_carry_lookahead_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N     = WIDTH / GROUP;
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] k_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             overflow_reg;

    logic [GROUP-1:0] grp_sum;
    logic             grp_cout;
    logic             grp_cmsb;

    // One lookahead slice shared by all groups, steered by k_reg
    cla_group #(.GROUP(GROUP)) u_cla (
        .a     (a_reg[k_reg*GROUP +: GROUP]),
        .b     (b_reg[k_reg*GROUP +: GROUP]),
        .cin   (carry_reg),
        .sum   (grp_sum),
        .c_out (grp_cout),
        .c_msb (grp_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            k_reg         <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_valid) begin
                        a_reg     <= a;
                        b_reg     <= b ^ {WIDTH{sub}};
                        carry_reg <= sub;
                        k_reg     <= '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    result_reg[k_reg*GROUP +: GROUP] <= grp_sum;
                    carry_reg <= grp_cout;
                    if (k_reg == LAST_K) begin
                        carry_out_reg <= grp_cout;
                        overflow_reg  <= grp_cmsb ^ grp_cout;
                        k_reg         <= '0;
                        state_reg     <= DONE;
                    end else begin
                        k_reg <= k_reg + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign start_ready = (state_reg == IDLE);
    assign res_valid   = (state_reg == DONE);
    assign result      = result_reg;
    assign carry_out   = carry_out_reg;
    assign overflow    = overflow_reg;
    assign zero        = (result_reg == '0);

endmodule
